// File: rtl/bt_pkg.sv
// Shared constants and FSM state type for the butterfly output skid buffer.
package bt_pkg;

  localparam int unsigned Q         = 8380417;
  localparam int unsigned COEF_W    = 23;
  localparam int unsigned BT_DATA_W = 2 * COEF_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } bt_skid_state_t;

endpackage

// File: rtl/bt_skid_reg.sv
// Load-enabled data register with asynchronous active-low clear.
module bt_skid_reg #(
  parameter int unsigned DATA_W = 46
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Capture d when load is high; clear to zero on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bt_skid_buffer.sv
// Two-entry skid buffer between the butterfly output and the memory write port.
// s_ready is registered so it never depends combinationally on m_ready.
// Optional feature: define BT_SKID_STALL_CNT_EN to add the stall_cnt output.
module bt_skid_buffer
  import bt_pkg::*;
#(
  parameter int unsigned DATA_W = BT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [1:0]        occ
`ifdef BT_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  bt_skid_state_t    state;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic              skid_load;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  // Handshake decode and register load strobes for the current state.
  always_comb begin
    in_xfer   = s_valid & s_ready;
    out_xfer  = m_valid & m_ready;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = s_data;
    unique case (state)
      EMPTY: main_load = in_xfer;
      HALF: begin
        main_load = in_xfer & out_xfer;
        skid_load = in_xfer & ~out_xfer;
      end
      FULL: begin
        main_load = out_xfer;
        main_d    = skid_q;
      end
      default: ;
    endcase
  end

  // Occupancy FSM; s_ready, m_valid and occ are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      occ     <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state   <= HALF;
            m_valid <= 1'b1;
            occ     <= 2'd1;
          end
        end
        HALF: begin
          if (in_xfer && !out_xfer) begin
            state   <= FULL;
            s_ready <= 1'b0;
            occ     <= 2'd2;
          end else if (!in_xfer && out_xfer) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            occ     <= 2'd0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state   <= HALF;
            s_ready <= 1'b1;
            occ     <= 2'd1;
          end
        end
        default: begin
          state   <= EMPTY;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          occ     <= 2'd0;
        end
      endcase
    end
  end

  bt_skid_reg #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (m_data)
  );

  bt_skid_reg #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (s_data),
    .q     (skid_q)
  );

`ifdef BT_SKID_STALL_CNT_EN
  // Saturating count of cycles where a word is offered but not taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bt_skid_buffer.sv
// Scoreboard bench for bt_skid_buffer: driver pushes accepted words, a
// negedge monitor tracks occupancy by counting and pops/compares outputs.
module tb_bt_skid_buffer;

  localparam int unsigned DW = 46;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [1:0]    occ;
`ifdef BT_SKID_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [DW-1:0] exp_q[$];

  bt_skid_buffer #(.DATA_W(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .occ     (occ)
`ifdef BT_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic sv, input logic [DW-1:0] d, input logic mr);
    @(posedge clk);
    #1;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    if (sv && s_ready) exp_q.push_back(d);
  endtask

  // Monitor: reference occupancy is simply words accepted minus words delivered.
  initial begin : monitor
    int unsigned   cnt;
    int unsigned   stall_m;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          in_x;
    logic          out_x;
    cnt = 0;
    stall_m = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt = 0;
        stall_m = 0;
        prev_stall = 1'b0;
        exp_q.delete();
      end else begin
        chk("occ", 64'(occ), 64'(cnt));
        chk("m_valid", 64'(m_valid), 64'(cnt != 0));
        chk("s_ready", 64'(s_ready), 64'(cnt < 2));
`ifdef BT_SKID_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
        if (prev_stall) chk("m_data_stable", 64'(m_data), 64'(prev_data));
        in_x  = s_valid && (cnt < 2);
        out_x = (cnt != 0) && m_ready;
        if (out_x) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL underflow: got output %0h expected no word", m_data);
          end else begin
            chk("m_data", 64'(m_data), 64'(exp_q.pop_front()));
          end
        end
        prev_stall = (cnt != 0) && !m_ready;
        if (prev_stall && stall_m < 32'hFFFF) stall_m++;
        prev_data = m_data;
        cnt = cnt + int'(in_x) - int'(out_x);
      end
    end
  end

  initial begin : stim
    logic [63:0] r;
    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_data", 64'(m_data), 64'd0);

    // Release reset and present a word on the first edge after it
    @(posedge clk);
    #1;
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 46'h1;
    m_ready = 1'b1;
    exp_q.push_back(46'h1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);

    // Fill to FULL then drain in order
    drive(1'b1, 46'hA, 1'b0);
    drive(1'b1, 46'hB, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 46'hC, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);

    // Back-to-back stream at full throughput
    for (int i = 1; i <= 100; i++) drive(1'b1, DW'(i), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);

    // Random handshakes
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom};
      drive(1'($urandom_range(0, 1)), r[DW-1:0], 1'($urandom_range(0, 1)));
    end

    // Reset while FULL: buffered words are discarded
    drive(1'b1, 46'h3C, 1'b0);
    drive(1'b1, 46'h3D, 1'b0);
    drive(1'b1, 46'h3E, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_occ", 64'(occ), 64'd0);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_data", 64'(m_data), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);

`ifdef BT_SKID_STALL_CNT_EN
    // Long stall saturates the counter
    drive(1'b1, 46'h77, 1'b0);
    for (int i = 0; i < 70000; i++) drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
`endif

    // Drain: bounded wait for all expected words to emerge
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
